// File: rtl/p2p_pool_reader.sv
// Read side of the P2P double-lane buffer: sweeps channel groups, absorbs BRAM latency and emits 1x2 max pooling.
// Optional macro POOL_RELU_EN: clamp negative pooled results to +0 (fused ReLU) at no extra latency.
module p2p_pool_reader #(
    parameter int DATA_WIDTH       = 16,
    parameter int POOL_PARALLELISM = 8,
    parameter int READ_LATENCY     = 1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic [7:0]                                num_channels,
    input  logic [DATA_WIDTH*POOL_PARALLELISM*2-1:0]  pool_input,
    output logic [7:0]                                pool_channel_sel,
    output logic [DATA_WIDTH*POOL_PARALLELISM-1:0]    pool_output,
    output logic [7:0]                                pool_ch_out,
    output logic                                      pool_valid,
    output logic                                      pool_last,
    output logic                                      busy,
    output logic                                      overrun
);
    localparam int DW  = DATA_WIDTH;
    localparam int PP  = POOL_PARALLELISM;
    localparam int LAT = READ_LATENCY;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t               r_state;
    logic [7:0]           r_num;
    logic [LAT-1:0]       r_tag_valid;
    logic [LAT-1:0]       r_tag_last;
    logic [7:0]           r_tag_ch [LAT];

    logic [8:0]           w_next_sel;
    logic                 w_last_group;
    logic                 w_issue;
    logic                 w_busy_start;
    logic                 w_accept;
    logic                 w_out_valid;
    logic                 w_out_last;
    logic [7:0]           w_out_ch;
    logic [DW*PP-1:0]     w_result;

    assign w_next_sel   = {1'b0, pool_channel_sel} + 9'(PP);
    assign w_last_group = (w_next_sel >= {1'b0, r_num});
    assign w_issue      = (r_state == S_ISSUE);
    // The cycle carrying the final beat still counts as busy for start arbitration.
    assign w_busy_start = start && ((r_state != S_IDLE) || (pool_valid && pool_last));
    assign w_accept     = start && !w_busy_start && (num_channels != 8'd0);
    assign w_out_valid  = r_tag_valid[LAT-1];
    assign w_out_last   = r_tag_last[LAT-1];
    assign w_out_ch     = r_tag_ch[LAT-1];

    // Tag pipe: one stage per cycle of read latency, aligned with pool_input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_valid <= '0;
            r_tag_last  <= '0;
            for (int i = 0; i < LAT; i++) r_tag_ch[i] <= '0;
        end else begin
            r_tag_valid[0] <= w_issue;
            r_tag_last[0]  <= w_issue && w_last_group;
            r_tag_ch[0]    <= pool_channel_sel;
            for (int i = 1; i < LAT; i++) begin
                r_tag_valid[i] <= r_tag_valid[i-1];
                r_tag_last[i]  <= r_tag_last[i-1];
                r_tag_ch[i]    <= r_tag_ch[i-1];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < PP; gi++) begin : g_elem
            logic [DW-1:0] w_a;
            logic [DW-1:0] w_b;
            logic [DW-1:0] w_max;
            logic [8:0]    w_ch;
            logic          w_zero;

            assign w_a  = pool_input[(2*gi)*DW +: DW];
            assign w_b  = pool_input[(2*gi+1)*DW +: DW];
            assign w_ch = {1'b0, w_out_ch} + 9'(gi);

            // Sign-magnitude max; ties keep lane A.
            always_comb begin
                w_max = w_a;
                if (w_a[DW-1] != w_b[DW-1])
                    w_max = w_a[DW-1] ? w_b : w_a;
                else if (!w_a[DW-1])
                    w_max = (w_b[DW-2:0] > w_a[DW-2:0]) ? w_b : w_a;
                else
                    w_max = (w_b[DW-2:0] < w_a[DW-2:0]) ? w_b : w_a;
            end

`ifdef POOL_RELU_EN
            assign w_zero = (w_ch >= {1'b0, r_num}) || (w_max[DW-2:0] == '0) || w_max[DW-1];
`else
            assign w_zero = (w_ch >= {1'b0, r_num}) || (w_max[DW-2:0] == '0);
`endif
            assign w_result[gi*DW +: DW] = w_zero ? '0 : w_max;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_num            <= '0;
            pool_channel_sel <= '0;
            pool_output      <= '0;
            pool_ch_out      <= '0;
            pool_valid       <= 1'b0;
            pool_last        <= 1'b0;
            busy             <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            if (w_busy_start) overrun <= 1'b1;
            pool_valid  <= w_out_valid;
            pool_last   <= w_out_valid && w_out_last;
            pool_ch_out <= w_out_valid ? w_out_ch : 8'd0;
            pool_output <= w_out_valid ? w_result : '0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_num            <= num_channels;
                        pool_channel_sel <= '0;
                        busy             <= 1'b1;
                        r_state          <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_last_group) begin
                        pool_channel_sel <= '0;
                        r_state          <= S_DRAIN;
                    end else begin
                        pool_channel_sel <= w_next_sel[7:0];
                    end
                end
                S_DRAIN: begin
                    if (w_out_valid && w_out_last) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_p2p_pool_reader.sv
// Randomized self-checking bench for p2p_pool_reader: two instances (read latency 1 and 2) fed by a BRAM model.
module tb_p2p_pool_reader;
    localparam int DW = 16;
    localparam int PP = 8;

    typedef struct {
        int           cyc;
        logic [7:0]   ch;
        logic [127:0] d;
        logic         last;
        logic         busy;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [255:0] mem [0:31];

    logic         rst1 = 1'b1, start1 = 1'b0, v1, l1, b1, o1;
    logic [7:0]   n1 = '0, sel1, ch1;
    logic [255:0] in1 = '0;
    logic [127:0] out1;
    logic         rst2 = 1'b1, start2 = 1'b0, v2, l2, b2, o2;
    logic [7:0]   n2 = '0, sel2, ch2, d2 = '0;
    logic [255:0] in2 = '0;
    logic [127:0] out2;

    beat_t q1[$];
    beat_t q2[$];

    p2p_pool_reader #(.DATA_WIDTH(DW), .POOL_PARALLELISM(PP), .READ_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .num_channels(n1), .pool_input(in1),
        .pool_channel_sel(sel1), .pool_output(out1), .pool_ch_out(ch1),
        .pool_valid(v1), .pool_last(l1), .busy(b1), .overrun(o1));

    p2p_pool_reader #(.DATA_WIDTH(DW), .POOL_PARALLELISM(PP), .READ_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .num_channels(n2), .pool_input(in2),
        .pool_channel_sel(sel2), .pool_output(out2), .pool_ch_out(ch2),
        .pool_valid(v2), .pool_last(l2), .busy(b2), .overrun(o2));

    // Buffer read ports with one and two cycles of latency.
    always @(posedge clk) begin
        in1 <= mem[sel1[7:3]];
        d2  <= sel2;
        in2 <= mem[d2[7:3]];
    end

    always @(negedge clk) begin
        if (v1) q1.push_back('{cyc, ch1, out1, l1, b1});
        if (v2) q2.push_back('{cyc, ch2, out2, l2, b2});
    end

    // Reference: compare as signed integers, re-encode as sign-magnitude (zero is always +0).
    function automatic logic [15:0] pool_max(input logic [15:0] a, input logic [15:0] b);
        int va, vb, r;
        va = a[15] ? -int'(a[14:0]) : int'(a[14:0]);
        vb = b[15] ? -int'(b[14:0]) : int'(b[14:0]);
        r  = (vb > va) ? vb : va;
`ifdef POOL_RELU_EN
        if (r < 0) r = 0;
`endif
        if (r < 0) return {1'b1, 15'(-r)};
        return {1'b0, 15'(r)};
    endfunction

    function automatic logic [127:0] exp_beat(input int g, input int n);
        logic [255:0] w;
        logic [127:0] res;
        w = mem[g];
        res = '0;
        for (int k = 0; k < PP; k++)
            if (g*PP + k < n) res[16*k +: 16] = pool_max(w[32*k +: 16], w[32*k+16 +: 16]);
        return res;
    endfunction

    task automatic fill_mem();
        for (int g = 0; g < 32; g++)
            for (int j = 0; j < 2*PP; j++)
                if ($urandom_range(0, 3) == 0)
                    mem[g][16*j +: 16] = {1'($urandom_range(0, 1)), 15'($urandom_range(0, 2))};
                else
                    mem[g][16*j +: 16] = 16'($urandom);
    endtask

    task automatic pulse1(input logic [7:0] n, output int t0);
        @(negedge clk);
        start1 = 1'b1; n1 = n; t0 = cyc;
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic pulse2(input logic [7:0] n, output int t0);
        @(negedge clk);
        start2 = 1'b1; n2 = n; t0 = cyc;
        @(negedge clk);
        start2 = 1'b0;
    endtask

    task automatic wait_idle1(output bit timeout);
        for (int i = 0; i < 300; i++) begin
            if (!b1 && !v1) break;
            @(negedge clk);
        end
        timeout = b1 || v1;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_idle2(output bit timeout);
        for (int i = 0; i < 300; i++) begin
            if (!b2 && !v2) break;
            @(negedge clk);
        end
        timeout = b2 || v2;
        repeat (3) @(negedge clk);
    endtask

    task automatic reset1();
        @(negedge clk); rst1 = 1'b1;
        @(negedge clk); rst1 = 1'b0;
        q1.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({sel1, out1, ch1, v1, l1, b1, o1} !== '0) begin
            errors++; $display("FAIL reset_dut1 got %h exp 0", {sel1, ch1, v1, l1, b1, o1});
        end
        checks++;
        if ({sel2, out2, ch2, v2, l2, b2, o2} !== '0) begin
            errors++; $display("FAIL reset_dut2 got %h exp 0", {sel2, ch2, v2, l2, b2, o2});
        end
        rst1 = 1'b0; rst2 = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({v1, b1, o1, v2, b2, o2} !== '0) begin
            errors++; $display("FAIL reset_release got %b exp 0", {v1, b1, o1, v2, b2, o2});
        end
        $display("reset: outputs idle");
    endtask

    task automatic test_basic();
        int t0; bit to;
        fill_mem(); q1.delete();
        pulse1(8'd16, t0);
        checks++;
        if (sel1 !== 8'd0 || b1 !== 1'b1) begin
            errors++; $display("FAIL basic_sel0 got sel=%0d busy=%b exp sel=0 busy=1", sel1, b1);
        end
        @(negedge clk);
        checks++;
        if (sel1 !== 8'd8) begin
            errors++; $display("FAIL basic_sel8 got %0d exp 8", sel1);
        end
        wait_idle1(to);
        checks++;
        if (to || q1.size() != 2) begin
            errors++; $display("FAIL basic_beats got %0d timeout=%b exp 2", q1.size(), to);
        end
        for (int i = 0; i < q1.size() && i < 2; i++) begin
            checks++;
            if (q1[i].cyc != t0 + 3 + i || q1[i].ch !== 8'(8*i) || q1[i].d !== exp_beat(i, 16) ||
                q1[i].last !== (i == 1) || q1[i].busy !== (i == 0)) begin
                errors++;
                $display("FAIL basic_beat%0d got t=%0d ch=%0d last=%b busy=%b d=%h exp t=%0d ch=%0d d=%h",
                         i, q1[i].cyc - t0, q1[i].ch, q1[i].last, q1[i].busy, q1[i].d, 3 + i, 8*i, exp_beat(i, 16));
            end
            $display("basic beat %0d ch=%0d last=%b", i, q1[i].ch, q1[i].last);
        end
    endtask

    task automatic test_max_rule();
        int t0; bit to;
        logic [15:0] req [4];
        req[0] = 16'h0009;
`ifdef POOL_RELU_EN
        req[1] = 16'h0000;
`else
        req[1] = 16'h8003;
`endif
        req[2] = 16'h0001;
        req[3] = 16'h0000;
        fill_mem(); q1.delete();
        mem[0][31:0]   = {16'h0009, 16'h0005};
        mem[0][63:32]  = {16'h8007, 16'h8003};
        mem[0][95:64]  = {16'h0001, 16'h8004};
        mem[0][127:96] = {16'h0000, 16'h8000};
        pulse1(8'd8, t0);
        wait_idle1(to);
        checks++;
        if (to || q1.size() != 1) begin
            errors++; $display("FAIL max_beats got %0d timeout=%b exp 1", q1.size(), to);
        end
        if (q1.size() >= 1) begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (q1[0].d[16*k +: 16] !== req[k]) begin
                    errors++; $display("FAIL max_pair%0d got %h exp %h", k, q1[0].d[16*k +: 16], req[k]);
                end
                $display("max pair %0d -> %h", k, q1[0].d[16*k +: 16]);
            end
            checks++;
            if (q1[0].d !== exp_beat(0, 8) || q1[0].last !== 1'b1) begin
                errors++; $display("FAIL max_word got %h exp %h", q1[0].d, exp_beat(0, 8));
            end
        end
    endtask

    task automatic test_partial();
        int t0; bit to;
        fill_mem(); q1.delete();
        pulse1(8'd12, t0);
        wait_idle1(to);
        checks++;
        if (to || q1.size() != 2) begin
            errors++; $display("FAIL partial_beats got %0d exp 2", q1.size());
        end
        if (q1.size() == 2) begin
            checks++;
            if (q1[1].d[127:64] !== 64'd0 || q1[1].last !== 1'b1 || q1[0].last !== 1'b0) begin
                errors++; $display("FAIL partial_tail got %h last=%b exp 0 last=1", q1[1].d[127:64], q1[1].last);
            end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (q1[i].d !== exp_beat(i, 12)) begin
                    errors++; $display("FAIL partial_beat%0d got %h exp %h", i, q1[i].d, exp_beat(i, 12));
                end
                $display("partial beat %0d ch=%0d last=%b", i, q1[i].ch, q1[i].last);
            end
        end
    endtask

    task automatic test_overrun();
        int t0, t1; bit to, seen;
        reset1(); fill_mem();
        pulse1(8'd16, t0);
        start1 = 1'b1; n1 = 8'd16;
        @(negedge clk);
        start1 = 1'b0;
        checks++;
        if (o1 !== 1'b1) begin
            errors++; $display("FAIL overrun_flag got %b exp 1", o1);
        end
        wait_idle1(to);
        checks++;
        if (to || q1.size() != 2) begin
            errors++; $display("FAIL overrun_beats got %0d exp 2", q1.size());
        end
        for (int i = 0; i < q1.size() && i < 2; i++) begin
            checks++;
            if (q1[i].cyc != t0 + 3 + i || q1[i].ch !== 8'(8*i) || q1[i].d !== exp_beat(i, 16)) begin
                errors++; $display("FAIL overrun_beat%0d got t=%0d d=%h exp t=%0d d=%h",
                                   i, q1[i].cyc - t0, q1[i].d, 3 + i, exp_beat(i, 16));
            end
        end
        $display("overrun: flag=%b beats=%0d", o1, q1.size());
        // start landing on the final beat must be rejected as well
        reset1();
        checks++;
        if (o1 !== 1'b0) begin
            errors++; $display("FAIL overrun_clear got %b exp 0", o1);
        end
        pulse1(8'd8, t1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (v1 && l1) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL lastbeat_wait got none exp pool_last");
        end
        start1 = 1'b1; n1 = 8'd8;
        @(negedge clk);
        start1 = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (o1 !== 1'b1 || b1 !== 1'b0 || q1.size() != 1) begin
            errors++; $display("FAIL lastbeat_start got ovr=%b busy=%b beats=%0d exp 1 0 1", o1, b1, q1.size());
        end
        $display("last-beat start: overrun=%b beats=%0d", o1, q1.size());
    endtask

    task automatic test_zero();
        int t0; bit busy_seen;
        reset1();
        pulse1(8'd0, t0);
        busy_seen = b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            busy_seen |= b1;
        end
        checks++;
        if (busy_seen || q1.size() != 0 || o1 !== 1'b0) begin
            errors++; $display("FAIL zero_start got busy=%b beats=%0d ovr=%b exp 0 0 0", busy_seen, q1.size(), o1);
        end
        $display("zero channels: busy=%b beats=%0d", busy_seen, q1.size());
    endtask

    task automatic test_random();
        int t0, n, groups; bit to;
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, 255);
            groups = (n + PP - 1) / PP;
            fill_mem(); q1.delete();
            pulse1(8'(n), t0);
            wait_idle1(to);
            checks++;
            if (to || q1.size() != groups) begin
                errors++; $display("FAIL rand_beats n=%0d got %0d exp %0d", n, q1.size(), groups);
            end
            for (int i = 0; i < q1.size() && i < groups; i++) begin
                checks++;
                if (q1[i].cyc != t0 + 3 + i || q1[i].ch !== 8'(PP*i) || q1[i].d !== exp_beat(i, n) ||
                    q1[i].last !== (i == groups - 1)) begin
                    errors++; $display("FAIL rand_beat n=%0d i=%0d got ch=%0d d=%h exp ch=%0d d=%h",
                                       n, i, q1[i].ch, q1[i].d, PP*i, exp_beat(i, n));
                end
            end
            $display("random sweep n=%0d beats=%0d", n, q1.size());
        end
    endtask

    task automatic test_latency2();
        int t0; bit to;
        fill_mem(); q2.delete();
        pulse2(8'd24, t0);
        wait_idle2(to);
        checks++;
        if (to || q2.size() != 3) begin
            errors++; $display("FAIL lat2_beats got %0d exp 3", q2.size());
        end
        for (int i = 0; i < q2.size() && i < 3; i++) begin
            checks++;
            if (q2[i].cyc != t0 + 4 + i || q2[i].ch !== 8'(8*i) || q2[i].d !== exp_beat(i, 24) ||
                q2[i].last !== (i == 2)) begin
                errors++; $display("FAIL lat2_beat%0d got t=%0d ch=%0d d=%h exp t=%0d ch=%0d d=%h",
                                   i, q2[i].cyc - t0, q2[i].ch, q2[i].d, 4 + i, 8*i, exp_beat(i, 24));
            end
            $display("lat2 beat %0d ch=%0d last=%b", i, q2[i].ch, q2[i].last);
        end
        q2.delete();
        pulse2(8'd24, t0);
        repeat (3) @(negedge clk);
        checks++;
        if (v2 !== 1'b1 || ch2 !== 8'd0) begin
            errors++; $display("FAIL lat2_t4 got valid=%b ch=%0d exp 1 0", v2, ch2);
        end
        #1 rst2 = 1'b1;
        @(negedge clk);
        rst2 = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (q2.size() != 1 || b2 !== 1'b0) begin
            errors++; $display("FAIL lat2_rst got beats=%0d busy=%b exp 1 0", q2.size(), b2);
        end
        $display("lat2 reset mid-sweep: beats=%0d", q2.size());
    endtask

    initial begin
        for (int g = 0; g < 32; g++) mem[g] = '0;
        test_reset();
        test_basic();
        test_max_rule();
        test_partial();
        test_overrun();
        test_zero();
        test_random();
        test_latency2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
